mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, width of the byte address.
REQ-002 Parameter: DATA_WIDTH, default 32, width of the word data.
REQ-003 Parameter: TIMEOUT, default 255, the maximum number of cycles spent waiting for mem_ack.
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 MemRead  in  1  load request from control (MemtoReg path).
REQ-007 MemWrite  in  1  store request from control.
REQ-008 Addr  in  ADDR_WIDTH  byte address, driven from the datapath ALUResult.
REQ-009 WriteData  in  DATA_WIDTH  store data from register file port RD2.
REQ-010 ReadData  out  DATA_WIDTH  load result to the datapath result mux.
REQ-011 Stall  out  1  high means the datapath holds PC and suppresses RegWrite.
REQ-012 AlignErr  out  1  one-cycle pulse on a misaligned access.
REQ-013 TimeoutErr  out  1  one-cycle pulse on a memory timeout.
REQ-014 mem_req  out  1  external memory request, held until acknowledged.
REQ-015 mem_we  out  1  external write enable, valid while mem_req=1.
REQ-016 mem_addr  out  ADDR_WIDTH  latched address.
REQ-017 mem_wdata  out  DATA_WIDTH  latched store data.
REQ-018 mem_rdata  in  DATA_WIDTH  memory read data, sampled on the mem_ack cycle.
REQ-019 mem_ack  in  1  memory completion, a single-cycle strobe.

Function
REQ-020 The FSM SHALL use the states IDLE, REQ and DONE.
REQ-021 In IDLE, MemRead|MemWrite with Addr[1:0]==0 SHALL:
- assert Stall combinationally in that cycle;
- latch Addr, WriteData and we=MemWrite;
- move to REQ.
REQ-022 MemRead and MemWrite asserted together SHALL be treated as a write.
REQ-023 In IDLE, a request with Addr[1:0]!=0 SHALL:
- pulse AlignErr on the next cycle;
- leave Stall low and issue no mem_req;
- leave ReadData unchanged.
REQ-024 In REQ, mem_req SHALL be 1, with Stall=1 and mem_addr, mem_we and mem_wdata held stable.
REQ-025 When mem_ack=1 in REQ:
- on a read, register mem_rdata into ReadData;
- go to DONE.
REQ-026 In DONE, Stall SHALL be 0 for exactly one cycle, requests SHALL be ignored, and the next state SHALL be IDLE.
REQ-027 Zero-wait access SHALL take 3 cycles (IDLE detect, REQ, DONE); each cycle of mem_ack delay adds exactly one cycle.
REQ-028 The wait counter SHALL:
- clear on entry to REQ and increment each REQ cycle without ack;
- on reaching TIMEOUT: drop mem_req, pulse TimeoutErr, set ReadData=0 on a read, go to DONE.
REQ-029 mem_ack outside REQ SHALL be ignored.
REQ-030 ReadData SHALL hold its last value until the next completed read.

Reset
REQ-031 While reset=0, the block SHALL immediately (asynchronously) set:
- state to IDLE and the wait counter to 0;
- mem_req, mem_we, AlignErr and TimeoutErr to 0;
- mem_addr, mem_wdata and ReadData to 0.
REQ-032 A reset asserted mid-transaction SHALL abandon it, with no ack capture and no error pulse.
REQ-033 The first request after reset deassertion SHALL be handled normally from IDLE.

Structure
REQ-034 Package mem_pkg SHALL hold the FSM state enum, the TIMEOUT default and the ADDR_WIDTH/DATA_WIDTH defaults.
REQ-035 The wait counter SHALL be a sub-module wait_counter (clear, enable, terminal-count output).
REQ-036 The FSM and the output registers SHALL live in mem_access_unit.

Verification
REQ-037 Read, Addr=0x10, ack on the first REQ cycle, mem_rdata=0xCAFEBABE:
- Stall high for 2 cycles;
- ReadData=0xCAFEBABE in DONE.
REQ-038 Write, Addr=0x20, WriteData=0x12345678, ack after 4 cycles:
- mem_we=1 and the data stable for 5 REQ cycles;
- Stall high for 6 cycles.
REQ-039 Read, Addr=0x13: AlignErr pulses once, mem_req stays 0, Stall stays 0.
REQ-040 Read with no ack, TIMEOUT=8:
- TimeoutErr pulses after 8 REQ cycles;
- ReadData=0, then the unit returns to IDLE.
REQ-041 reset=0 during REQ: mem_req falls immediately; after release, a new read completes normally.
REQ-042 MemRead=MemWrite=1 at Addr=0x40: mem_we=1 and ReadData unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the load/store memory access unit.
package mem_pkg;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side load/store controls plus the external memory request bus.
interface mem_access_unit_if import mem_pkg::*; #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
   logic                  MemRead;
   logic                  MemWrite;
   logic [ADDR_WIDTH-1:0] Addr;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [DATA_WIDTH-1:0] ReadData;
   logic                  Stall;
   logic                  AlignErr;
   logic                  TimeoutErr;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   modport master (
      input  MemRead, MemWrite, Addr, WriteData, mem_rdata, mem_ack,
      output ReadData, Stall, AlignErr, TimeoutErr,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output MemRead, MemWrite, Addr, WriteData, mem_rdata, mem_ack,
      input  ReadData, Stall, AlignErr, TimeoutErr,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/wait_counter.sv
// Counts un-acknowledged request cycles; tc flags the cycle whose increment reaches LIMIT.
module wait_counter import mem_pkg::*; #(
   parameter int LIMIT = DEF_TIMEOUT,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + WIDTH'(1);
   end

   assign tc = enable && (count == WIDTH'(LIMIT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// Word-aligned load/store sequencer: IDLE detect, REQ until ack or timeout, one DONE cycle.
// Latency 3 cycles plus one per cycle of ack delay; Stall holds the datapath meanwhile.
module mem_access_unit import mem_pkg::*; #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input logic               clk,
   input logic               reset,
   mem_access_unit_if.master bus
);
   state_t                state, state_nxt;
   logic                  req_any, aligned;
   logic                  start, acked, timed_out, tc;
   logic                  we_q, align_err_q, timeout_err_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

   assign req_any = bus.MemRead | bus.MemWrite;
   assign aligned = (bus.Addr[1:0] == 2'b00);

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      acked     = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: if (req_any && aligned) begin
            start     = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (bus.mem_ack) begin
            acked     = 1'b1;
            state_nxt = DONE;
         end else if (tc) begin
            timed_out = 1'b1;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   wait_counter #(.LIMIT(TIMEOUT)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (start),
      .enable ((state == REQ) && !bus.mem_ack),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         align_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         align_err_q   <= (state == IDLE) && req_any && !aligned;
         timeout_err_q <= timed_out;
         // MemWrite alone decides direction, so a read+write collision becomes a store
         if (start) begin
            addr_q  <= bus.Addr;
            wdata_q <= bus.WriteData;
            we_q    <= bus.MemWrite;
         end
         if (acked && !we_q)
            rdata_q <= bus.mem_rdata;
         else if (timed_out && !we_q)
            rdata_q <= '0;
      end
   end

   assign bus.Stall      = start || (state == REQ);
   assign bus.mem_req    = (state == REQ);
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.ReadData   = rdata_q;
   assign bus.AlignErr   = align_err_q;
   assign bus.TimeoutErr = timeout_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner case, random traffic vs a transaction-level model.
module tb_mem_access_unit;
   localparam int TO = 8;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      int          e_stall;
      int          e_req;
      logic        e_align;
      logic        e_to;
      logic [31:0] e_rd;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model_rd;
   vec_t tbl[8];

   mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Transaction-level expectation: aligned accesses wait delay+1 REQ cycles, capped at TO.
   function automatic vec_t predict(input vec_t v, input logic [31:0] cur);
      vec_t r = v;
      if (v.addr % 4 != 0) begin
         r.e_stall = 0; r.e_req = 0; r.e_align = 1'b1; r.e_to = 1'b0; r.e_rd = cur;
      end else begin
         r.e_to    = (v.delay >= TO);
         r.e_req   = r.e_to ? TO : v.delay + 1;
         r.e_stall = r.e_req + 1;
         r.e_align = 1'b0;
         r.e_rd    = (v.rd && !v.wr) ? (r.e_to ? 32'h0 : v.rdata) : cur;
      end
      return r;
   endfunction

   task automatic do_txn(input vec_t v, input string nm);
      int stall_cnt = 0, req_cnt = 0, bad_hold = 0, align_cnt = 0, to_cnt = 0, guard = 0;
      int hold = v.e_stall;
      int rd_at = (v.e_stall > 0) ? v.e_stall : 1;
      for (int i = 0; i < v.e_stall + 2; i++) begin
         bus.MemRead   = (i <= hold) ? v.rd : 1'b0;
         bus.MemWrite  = (i <= hold) ? v.wr : 1'b0;
         bus.Addr      = v.addr;
         bus.WriteData = v.wdata;
         #1;
         if (i == 0) chk({nm, "_stall_first"}, 64'(bus.Stall), 64'(v.e_stall > 0));
         stall_cnt += int'(bus.Stall);
         align_cnt += int'(bus.AlignErr);
         to_cnt    += int'(bus.TimeoutErr);
         if (bus.mem_req) begin
            req_cnt++;
            if (bus.mem_addr !== v.addr || bus.mem_wdata !== v.wdata || bus.mem_we !== v.wr)
               bad_hold++;
         end
         if (i == rd_at) chk({nm, "_readdata"}, 64'(bus.ReadData), 64'(v.e_rd));
         bus.mem_ack   = bus.mem_req && (req_cnt - 1 == v.delay);
         bus.mem_rdata = v.rdata;
         @(negedge clk);
      end
      bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.mem_ack = 1'b0;
      chk({nm, "_stall_cycles"}, 64'(stall_cnt), 64'(v.e_stall));
      chk({nm, "_req_cycles"}, 64'(req_cnt), 64'(v.e_req));
      chk({nm, "_req_fields"}, 64'(bad_hold), 64'd0);
      chk({nm, "_align_pulses"}, 64'(align_cnt), 64'(v.e_align));
      chk({nm, "_timeout_pulses"}, 64'(to_cnt), 64'(v.e_to));
      #1;
      chk({nm, "_idle_after"}, 64'({bus.Stall, bus.mem_req}), 64'd0);
      while ((bus.Stall || bus.mem_req) && guard < 40) begin
         bus.mem_ack = bus.mem_req;
         @(negedge clk); #1;
         guard++;
      end
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   bad;
      bus.MemRead = 0; bus.MemWrite = 0; bus.Addr = 0; bus.WriteData = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;

      tbl[0] = '{1, 0, 32'h10, 32'h0,        32'hCAFEBABE, 0,  2, 1, 0, 0, 32'hCAFEBABE};
      tbl[1] = '{0, 1, 32'h20, 32'h12345678, 32'hDEAD0000, 4,  6, 5, 0, 0, 32'hCAFEBABE};
      tbl[2] = '{1, 0, 32'h13, 32'h0,        32'h55555555, 0,  0, 0, 1, 0, 32'hCAFEBABE};
      tbl[3] = '{1, 0, 32'h30, 32'h0,        32'h11111111, 99, 9, 8, 0, 1, 32'h0};
      tbl[4] = '{1, 1, 32'h40, 32'hA5A5A5A5, 32'h77777777, 1,  3, 2, 0, 0, 32'h0};
      tbl[5] = '{1, 0, 32'h44, 32'h0,        32'h0BADF00D, 7,  9, 8, 0, 0, 32'h0BADF00D};
      tbl[6] = '{0, 1, 32'h22, 32'h9,        32'h0,        0,  0, 0, 1, 0, 32'h0BADF00D};
      tbl[7] = '{1, 0, 32'h48, 32'h0,        32'h13572468, 2,  4, 3, 0, 0, 32'h13572468};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_readdata", 64'(bus.ReadData), 64'd0);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_errs", 64'({bus.AlignErr, bus.TimeoutErr, bus.Stall}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Acks arriving while idle must not disturb ReadData.
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      chk("stray_ack_readdata", 64'(bus.ReadData), 64'd0);
      @(negedge clk);

      for (int k = 0; k < 8; k++) do_txn(tbl[k], $sformatf("vec%0d", k));
      model_rd = tbl[7].e_rd;

      // Reset dropped mid-REQ abandons the access.
      @(negedge clk);
      bus.MemRead = 1'b1; bus.Addr = 32'h60;
      @(negedge clk);
      #1;
      chk("rst_mid_req_before", 64'(bus.mem_req), 64'd1);
      #1;
      bus.MemRead = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_mid_req_drop", 64'(bus.mem_req), 64'd0);
      chk("rst_mid_stall", 64'(bus.Stall), 64'd0);
      chk("rst_mid_readdata", 64'(bus.ReadData), 64'd0);
      chk("rst_mid_mem_addr", 64'(bus.mem_addr), 64'd0);
      bad = 0;
      repeat (2) begin
         @(negedge clk); #1;
         bad += int'(bus.AlignErr) + int'(bus.TimeoutErr);
      end
      reset = 1'b1;
      @(negedge clk); #1;
      bad += int'(bus.AlignErr) + int'(bus.TimeoutErr);
      chk("rst_mid_no_err", 64'(bad), 64'd0);
      v = '{1, 0, 32'h64, 32'h0, 32'h2468ACE0, 1, 3, 2, 0, 0, 32'h2468ACE0};
      do_txn(v, "post_reset");
      model_rd = 32'h2468ACE0;

      for (int k = 0; k < 40; k++) begin
         int r = $urandom_range(0, 2);
         v.rd    = (r != 1);
         v.wr    = (r != 0);
         v.addr  = $urandom() & 32'hFFFFFFFC;
         if ($urandom_range(0, 3) == 0) v.addr = v.addr | 32'($urandom_range(1, 3));
         v.wdata = $urandom();
         v.rdata = $urandom();
         v.delay = $urandom_range(0, 10);
         v = predict(v, model_rd);
         do_txn(v, $sformatf("rnd%0d", k));
         model_rd = v.e_rd;
         bus.mem_ack   = 1'($urandom_range(0, 1));
         bus.mem_rdata = $urandom();
         @(negedge clk);
         bus.mem_ack = 1'b0;
      end
      #1;
      chk("final_readdata", 64'(bus.ReadData), 64'(model_rd));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
